// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Purpose
//   Elastic pipeline register for one processor pipeline stage. It carries a
//   payload (operands / immediate / PC) and a control bundle (WriteBack,
//   MemoryRead, MemoryWrite, aluOP, AluSrc, ...) between two stages using a
//   valid/ready handshake.
//
//   SKID_EN = 1 : two-entry stage (main + skid). in_ready is a register, so
//                 the upstream ready path does not depend combinationally on
//                 out_ready, and throughput stays at one beat per cycle.
//   SKID_EN = 0 : single-entry stage. in_ready = out_ready || !out_valid,
//                 combinational, which allows accept and pop in one cycle.
//
//   A flush (branch/jump redirect) empties the stage at the next edge and
//   discards any beat offered in the flush cycle. When the stage is empty,
//   out_ctrl is forced to zero so that a bubble can never write back or
//   touch memory; out_data keeps the last main-entry value.
//
//   Two saturating performance counters observe the output port:
//   stall_cnt  : cycles with out_valid && !out_ready (downstream backpressure)
//   bubble_cnt : cycles with out_valid == 0 (excluding reset cycles)
//
// Ports
//   clk         in   1       sole clock, rising edge
//   rst         in   1       synchronous active-high reset (beats flush)
//   flush       in   1       kill stage contents (beats accept/pop)
//   in_valid    in   1       upstream beat valid
//   in_ready    out  1       stage can accept a beat
//   in_data     in   DATA_W  upstream payload
//   in_ctrl     in   CTRL_W  upstream control bundle
//   out_valid   out  1       downstream beat valid (occ > 0)
//   out_ready   in   1       downstream accept (inverse of stall)
//   out_data    out  DATA_W  downstream payload (main entry)
//   out_ctrl    out  CTRL_W  downstream control bundle, zero when bubble
//   occ         out  2       number of held beats (0..2)
//   stall_cnt   out  CNT_W   saturating backpressure cycle counter
//   bubble_cnt  out  CNT_W   saturating empty-output cycle counter
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
   parameter int DATA_W  = 32,
   parameter int CTRL_W  = 12,
   parameter int SKID_EN = 1,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
);

   // EMPTY: nothing held. FULL: main entry holds the output beat.
   // SKID : main entry is the output beat, skid entry holds the next one.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } state_e;

   state_e              state_q,      state_d;
   logic [DATA_W-1:0]   main_data_q,  main_data_d;
   logic [CTRL_W-1:0]   main_ctrl_q,  main_ctrl_d;
   logic [DATA_W-1:0]   skid_data_q,  skid_data_d;
   logic [CTRL_W-1:0]   skid_ctrl_q,  skid_ctrl_d;
   logic [1:0]          occ_q,        occ_d;
   logic                in_ready_q,   in_ready_d;
   logic [CNT_W-1:0]    stall_cnt_q,  stall_cnt_d;
   logic [CNT_W-1:0]    bubble_cnt_q, bubble_cnt_d;

   logic                accept;
   logic                pop;

   // -------------------------------------------------------------------------
   // Handshake
   // -------------------------------------------------------------------------
   assign out_valid = (state_q != EMPTY);

   // In the two-entry stage in_ready comes straight from a flop. OR-ing in rst
   // keeps it high while reset is applied, before the flop has been cleared;
   // anything accepted then is dropped by the reset anyway.
   assign in_ready  = (SKID_EN != 0) ? (in_ready_q | rst)
                                     : (out_ready | ~out_valid);

   assign accept    = in_valid  & in_ready;
   assign pop       = out_valid & out_ready;

   // -------------------------------------------------------------------------
   // Next-state / datapath
   // -------------------------------------------------------------------------
   // NOTE: every *_d gets a default (hold) first, so no path through the case
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      main_ctrl_d = main_ctrl_q;
      skid_data_d = skid_data_q;
      skid_ctrl_d = skid_ctrl_q;

      if (flush) begin
         // Redirect: drop everything held and whatever is offered this cycle.
         // A pop in this cycle has already been consumed downstream.
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_d     = FULL;
                  main_data_d = in_data;
                  main_ctrl_d = in_ctrl;
               end
            end

            FULL: begin
               if (accept && pop) begin
                  // Streaming: the outgoing beat is replaced in place.
                  main_data_d = in_data;
                  main_ctrl_d = in_ctrl;
               end else if (pop) begin
                  state_d = EMPTY;
               end else if (accept && (SKID_EN != 0)) begin
                  // Downstream stalled but in_ready was still high (it is a
                  // flop): park the beat behind the main entry.
                  state_d     = SKID;
                  skid_data_d = in_data;
                  skid_ctrl_d = in_ctrl;
               end
            end

            SKID: begin
               // in_ready is low here, so only a pop can happen.
               if (pop) begin
                  state_d     = FULL;
                  main_data_d = skid_data_q;
                  main_ctrl_d = skid_ctrl_q;
               end
            end

            default: begin
               state_d = EMPTY;
            end
         endcase
      end

      // Occupancy and registered ready follow the next state, so they change
      // on the same edge as the state itself.
      case (state_d)
         FULL:    occ_d = 2'd1;
         SKID:    occ_d = 2'd2;
         default: occ_d = 2'd0;
      endcase
      in_ready_d = (state_d != SKID);

      // Performance counters look only at the output port, so flush does not
      // affect them; they saturate instead of wrapping.
      stall_cnt_d = stall_cnt_q;
      if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end

      bubble_cnt_d = bubble_cnt_q;
      if (!out_valid && (bubble_cnt_q != {CNT_W{1'b1}})) begin
         bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   // NOTE: non-blocking assignments here so every flop samples the values from
   // before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the payload registers are reset too (not just the valid
         // state) because out_data is visible while empty and must read zero
         // after reset.
         state_q      <= EMPTY;
         main_data_q  <= '0;
         main_ctrl_q  <= '0;
         skid_data_q  <= '0;
         skid_ctrl_q  <= '0;
         occ_q        <= 2'd0;
         in_ready_q   <= 1'b1;
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         main_data_q  <= main_data_d;
         main_ctrl_q  <= main_ctrl_d;
         skid_data_q  <= skid_data_d;
         skid_ctrl_q  <= skid_ctrl_d;
         occ_q        <= occ_d;
         in_ready_q   <= in_ready_d;
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign out_data   = main_data_q;
   // A bubble must carry no control so downstream never acts on stale bits.
   assign out_ctrl   = out_valid ? main_ctrl_q : '0;
   assign occ        = occ_q;
   assign stall_cnt  = stall_cnt_q;
   assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Three copies of pipe_stage_reg share one stimulus stream:
//   u0 : SKID_EN=1, CNT_W=16
//   u1 : SKID_EN=0, CNT_W=16
//   u2 : SKID_EN=1, CNT_W=4   (counter saturation)
// Each copy is compared every cycle against a FIFO-with-capacity model, and
// directed sequences / a vector table add fixed expected values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipe_stage_reg;

   localparam int DW = 32;
   localparam int CW = 12;
   localparam int NI = 3;
   localparam logic H = 1'b1;
   localparam logic L = 1'b0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, flush, in_valid, out_ready;
   logic [DW-1:0] in_data;
   logic [CW-1:0] in_ctrl;

   logic          ir0, ov0, ir1, ov1, ir2, ov2;
   logic [DW-1:0] od0, od1, od2;
   logic [CW-1:0] oc0, oc1, oc2;
   logic [1:0]    occ0, occ1, occ2;
   logic [15:0]   sc0, bc0, sc1, bc1;
   logic [3:0]    sc2, bc2;

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1), .CNT_W(16)) u0 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
      .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov0), .out_ready(out_ready),
      .out_data(od0), .out_ctrl(oc0), .occ(occ0), .stall_cnt(sc0), .bubble_cnt(bc0));

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(0), .CNT_W(16)) u1 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
      .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov1), .out_ready(out_ready),
      .out_data(od1), .out_ctrl(oc1), .occ(occ1), .stall_cnt(sc1), .bubble_cnt(bc1));

   pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1), .CNT_W(4)) u2 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir2),
      .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov2), .out_ready(out_ready),
      .out_data(od2), .out_ctrl(oc2), .occ(occ2), .stall_cnt(sc2), .bubble_cnt(bc2));

   typedef struct {
      logic          ir;
      logic          ov;
      logic [DW-1:0] od;
      logic [CW-1:0] oc;
      logic [1:0]    occ;
      logic [15:0]   sc;
      logic [15:0]   bc;
   } obs_t;

   obs_t obs [NI];

   always_comb begin
      obs[0] = '{ir: ir0, ov: ov0, od: od0, oc: oc0, occ: occ0, sc: sc0, bc: bc0};
      obs[1] = '{ir: ir1, ov: ov1, od: od1, oc: oc1, occ: occ1, sc: sc1, bc: bc1};
      obs[2] = '{ir: ir2, ov: ov2, od: od2, oc: oc2, occ: occ2,
                 sc: {12'd0, sc2}, bc: {12'd0, bc2}};
   end

   // ---------------------------------------------------------------------------
   // Reference model: a FIFO of held beats with a capacity (2 or 1), plus the
   // last beat that was at the head (what out_data shows when empty).
   // ---------------------------------------------------------------------------
   int            m_cnt   [NI];
   logic [DW-1:0] m_d     [NI][2];
   logic [CW-1:0] m_c     [NI][2];
   logic [DW-1:0] m_last  [NI];
   int            m_stall [NI];
   int            m_bub   [NI];
   int            m_cap   [NI] = '{2, 1, 2};
   int            m_max   [NI] = '{65535, 65535, 15};
   bit            m_init = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Whether the stage can take a beat this cycle, from occupancy alone.
   function automatic logic model_ready(input int i);
      if (m_cap[i] == 2) return rst || (m_cnt[i] < 2);
      else               return (m_cnt[i] == 0) || out_ready;
   endfunction

   task automatic model_step(input int i, input logic acc);
      if (rst) begin
         m_cnt[i] = 0; m_last[i] = '0; m_stall[i] = 0; m_bub[i] = 0;
      end else begin
         if (m_cnt[i] > 0 && !out_ready && m_stall[i] < m_max[i]) m_stall[i]++;
         if (m_cnt[i] == 0 && m_bub[i] < m_max[i]) m_bub[i]++;
         if (flush) begin
            m_cnt[i] = 0;
         end else begin
            if (m_cnt[i] > 0 && out_ready) begin
               m_d[i][0] = m_d[i][1];
               m_c[i][0] = m_c[i][1];
               m_cnt[i]--;
            end
            if (acc) begin
               m_d[i][m_cnt[i]] = in_data;
               m_c[i][m_cnt[i]] = in_ctrl;
               m_cnt[i]++;
            end
         end
         if (m_cnt[i] > 0) m_last[i] = m_d[i][0];
      end
   endtask

   task automatic compare(input int i);
      logic [CW-1:0] ec;
      ec = (m_cnt[i] > 0) ? m_c[i][0] : '0;
      check($sformatf("u%0d.out_valid", i), 32'(obs[i].ov), 32'(m_cnt[i] > 0));
      check($sformatf("u%0d.out_data", i), obs[i].od, m_last[i]);
      check($sformatf("u%0d.out_ctrl", i), 32'(obs[i].oc), 32'(ec));
      check($sformatf("u%0d.occ", i), 32'(obs[i].occ), 32'(m_cnt[i]));
      check($sformatf("u%0d.stall_cnt", i), 32'(obs[i].sc), 32'(m_stall[i]));
      check($sformatf("u%0d.bubble_cnt", i), 32'(obs[i].bc), 32'(m_bub[i]));
   endtask

   // Apply inputs for the coming edge and check in_ready before the edge.
   task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                        input logic ordy, input logic fl, input logic r);
      in_valid = v; in_data = d; in_ctrl = c; out_ready = ordy; flush = fl; rst = r;
      #1;
      if (m_init) begin
         for (int i = 0; i < NI; i++)
            check($sformatf("u%0d.in_ready", i), 32'(obs[i].ir), 32'(model_ready(i)));
      end
   endtask

   // Clock edge, then update the model and compare all outputs.
   task automatic tick();
      logic acc [NI];
      for (int i = 0; i < NI; i++) acc[i] = in_valid && model_ready(i);
      @(posedge clk);
      #1;
      if (rst) m_init = 1'b1;
      for (int i = 0; i < NI; i++) begin
         model_step(i, acc[i]);
         if (m_init) compare(i);
      end
   endtask

   task automatic cyc(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                      input logic ordy, input logic fl, input logic r);
      drive(v, d, c, ordy, fl, r);
      tick();
   endtask

   // ---------------------------------------------------------------------------
   // Vector table for the two-entry stage (u0): backpressure and flush-in-SKID.
   // Expected values are the outputs just after the edge.
   // ---------------------------------------------------------------------------
   typedef struct {
      logic          v;
      logic [DW-1:0] d;
      logic [CW-1:0] c;
      logic          ordy;
      logic          fl;
      logic          e_ov;
      logic [DW-1:0] e_od;
      logic [CW-1:0] e_oc;
      logic [1:0]    e_occ;
      logic          e_ir;
      int            e_sc;
   } vec_t;

   vec_t tbl [12];

   initial begin
      //          v  data     ctrl     rdy fl  ov  out_data out_ctrl occ    ir  stall
      tbl[0]  = '{H, 32'hA,  12'h00A, L,  L,  H,  32'hA,   12'h00A, 2'd1,  H,  0};
      tbl[1]  = '{H, 32'hB,  12'h00B, L,  L,  H,  32'hA,   12'h00A, 2'd2,  L,  1};
      tbl[2]  = '{H, 32'hC,  12'h00C, L,  L,  H,  32'hA,   12'h00A, 2'd2,  L,  2};
      tbl[3]  = '{L, 32'h0,  12'h000, H,  L,  H,  32'hB,   12'h00B, 2'd1,  H,  2};
      tbl[4]  = '{L, 32'h0,  12'h000, H,  L,  L,  32'hB,   12'h000, 2'd0,  H,  2};
      tbl[5]  = '{L, 32'h0,  12'h000, H,  L,  L,  32'hB,   12'h000, 2'd0,  H,  2};
      tbl[6]  = '{H, 32'h11, 12'h011, L,  L,  H,  32'h11,  12'h011, 2'd1,  H,  2};
      tbl[7]  = '{H, 32'h22, 12'h022, L,  L,  H,  32'h11,  12'h011, 2'd2,  L,  3};
      tbl[8]  = '{H, 32'h33, 12'h033, L,  H,  L,  32'h11,  12'h000, 2'd0,  H,  4};
      tbl[9]  = '{L, 32'h0,  12'h000, H,  L,  L,  32'h11,  12'h000, 2'd0,  H,  4};
      tbl[10] = '{H, 32'h44, 12'h044, H,  L,  H,  32'h44,  12'h044, 2'd1,  H,  4};
      tbl[11] = '{L, 32'h0,  12'h000, H,  L,  L,  32'h44,  12'h000, 2'd0,  H,  4};

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_data = '0; in_ctrl = '0;

      // --- reset held for two cycles ---
      cyc(L, 32'h0, 12'h0, H, L, H);
      cyc(L, 32'h0, 12'h0, H, L, H);
      check("reset out_valid",  32'(ov0),  32'd0);
      check("reset out_ctrl",   32'(oc0),  32'd0);
      check("reset out_data",   od0,       32'd0);
      check("reset occ",        32'(occ0), 32'd0);
      check("reset in_ready",   32'(ir0),  32'd1);
      check("reset stall_cnt",  32'(sc0),  32'd0);
      check("reset bubble_cnt", 32'(bc0),  32'd0);

      // --- streaming 1,2,3 at full throughput ---
      cyc(H, 32'd1, 12'h101, H, L, L);
      check("stream beat1 data", od0, 32'd1);
      check("stream beat1 occ", 32'(occ0), 32'd1);
      cyc(H, 32'd2, 12'h102, H, L, L);
      check("stream beat2 data", od0, 32'd2);
      check("stream beat2 occ", 32'(occ0), 32'd1);
      cyc(H, 32'd3, 12'h103, H, L, L);
      check("stream beat3 data", od0, 32'd3);
      check("stream beat3 ctrl", 32'(oc0), 32'h103);
      check("stream beat3 occ", 32'(occ0), 32'd1);
      check("stream stall_cnt", 32'(sc0), 32'd0);
      cyc(L, 32'h0, 12'h0, H, L, L);
      check("stream drained", 32'(ov0), 32'd0);

      // --- table: backpressure, then flush while in SKID ---
      cyc(L, 32'h0, 12'h0, H, L, H);
      for (int k = 0; k < 12; k++) begin
         cyc(tbl[k].v, tbl[k].d, tbl[k].c, tbl[k].ordy, tbl[k].fl, L);
         check($sformatf("vec%0d out_valid", k), 32'(ov0), 32'(tbl[k].e_ov));
         check($sformatf("vec%0d out_data", k), od0, tbl[k].e_od);
         check($sformatf("vec%0d out_ctrl", k), 32'(oc0), 32'(tbl[k].e_oc));
         check($sformatf("vec%0d occ", k), 32'(occ0), 32'(tbl[k].e_occ));
         check($sformatf("vec%0d in_ready", k), 32'(ir0), 32'(tbl[k].e_ir));
         check($sformatf("vec%0d stall_cnt", k), 32'(sc0), 32'(tbl[k].e_sc));
      end

      // --- stall counter saturation on the 4-bit copy ---
      cyc(L, 32'h0, 12'h0, H, L, H);
      cyc(H, 32'h77, 12'h077, L, L, L);
      for (int k = 0; k < 20; k++) cyc(L, 32'h0, 12'h0, L, L, L);
      check("sat u2 stall_cnt", 32'(sc2), 32'd15);
      check("sat u0 stall_cnt", 32'(sc0), 32'd20);
      cyc(L, 32'h0, 12'h0, L, L, L);
      check("sat u2 stall_cnt holds", 32'(sc2), 32'd15);

      // --- single-entry stage: combinational in_ready, accept+pop together ---
      cyc(L, 32'h0, 12'h0, H, L, H);
      cyc(H, 32'h55, 12'h055, L, L, L);
      check("u1 full data", od1, 32'h55);
      drive(H, 32'h66, 12'h066, L, L, L);
      check("u1 in_ready stalled", 32'(ir1), 32'd0);
      drive(H, 32'h66, 12'h066, H, L, L);
      check("u1 in_ready released", 32'(ir1), 32'd1);
      tick();
      check("u1 D data", od1, 32'h66);
      check("u1 D ctrl", 32'(oc1), 32'h066);
      check("u1 D occ", 32'(occ1), 32'd1);
      cyc(L, 32'h0, 12'h0, H, L, L);
      check("u1 D drained", 32'(ov1), 32'd0);

      // --- reset in the middle of a full skid stage ---
      cyc(H, 32'h88, 12'h088, L, L, L);
      cyc(H, 32'h99, 12'h099, L, L, L);
      check("pre-rst occ", 32'(occ0), 32'd2);
      cyc(H, 32'hAA, 12'h0AA, H, L, H);
      cyc(L, 32'h0, 12'h0, H, L, L);
      check("post-rst out_valid", 32'(ov0), 32'd0);
      check("post-rst out_data", od0, 32'd0);

      // --- randomized traffic against the model ---
      for (int k = 0; k < 800; k++) begin
         logic v, ordy, fl, r;
         int   bias;
         bias = (k / 100) % 4;
         v    = ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 3) >= bias);
         fl   = ($urandom_range(0, 24) == 0);
         r    = ($urandom_range(0, 149) == 0);
         cyc(v, $urandom, 12'($urandom), ordy, fl, r);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, 32, width of the stage payload (operands, immediate, PC).
REQ-002 SHALL have parameter CTRL_W, 12, width of the stage control bundle (WriteBack, MemoryRead, MemoryWrite, aluOP, AluSrc and similar).
REQ-003 SHALL have parameter SKID_EN, 1, where 1 selects a two-entry elastic stage and 0 selects a single-entry stage.
REQ-004 SHALL have parameter CNT_W, 16, width of the performance counters.
REQ-005 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port flush, input, 1, which kills stage contents (branch/jump redirect).
REQ-008 SHALL have port in_valid, input, 1, which marks the upstream beat as valid.
REQ-009 SHALL have port in_ready, output, 1, which indicates the stage can accept a beat.
REQ-010 SHALL have port in_data, input, DATA_W, upstream payload.
REQ-011 SHALL have port in_ctrl, input, CTRL_W, upstream control bundle.
REQ-012 SHALL have port out_valid, output, 1, which marks the downstream beat as valid.
REQ-013 SHALL have port out_ready, input, 1, which is the downstream accept (inverse of stall).
REQ-014 SHALL have port out_data, output, DATA_W, downstream payload.
REQ-015 SHALL have port out_ctrl, output, CTRL_W, downstream control bundle.
REQ-016 SHALL have port occ, output, 2, which gives the number of held beats (0..2).
REQ-017 SHALL have port stall_cnt, output, CNT_W, which counts backpressured cycles.
REQ-018 SHALL have port bubble_cnt, output, CNT_W, which counts empty-output cycles.

Function
REQ-019 SHALL define accept as in_valid && in_ready and pop as out_valid && out_ready, both sampled at the rising edge.
REQ-020 SHALL, when SKID_EN=1, use states EMPTY, FULL and SKID, with in_ready registered: 1 in EMPTY/FULL and 0 in SKID.
REQ-021 SHALL transition EMPTY --accept--> FULL (main entry loaded); otherwise it stays in EMPTY.
REQ-022 SHALL, in FULL: on accept&pop, stay FULL with main entry replaced; on pop only, go to EMPTY; on accept only, go to SKID with the skid entry loaded; on neither, hold.
REQ-023 SHALL, in SKID: on pop, go to FULL with main entry taken from skid; otherwise hold.
REQ-024 SHALL, when SKID_EN=0, be single-entry with in_ready = out_ready || !out_valid (combinational), and support accept and pop in the same cycle.
REQ-025 SHALL present beats on the output exactly in acceptance order, with no duplication and no loss except by flush.
REQ-026 SHALL have latency of one cycle from accept to out_valid when the stage is empty.
REQ-027 SHALL have full throughput: one beat per cycle when out_ready is held at 1.
REQ-028 SHALL drive out_valid=1 iff occ>0; out_data/out_ctrl come from the main entry.
REQ-029 SHALL force out_ctrl to all zeros whenever out_valid=0 (bubble), while out_data holds its last value.
REQ-030 SHALL, on flush, go to EMPTY (occ=0, out_valid=0, out_ctrl=0) on the next cycle.
REQ-031 SHALL discard any beat accepted in a flush cycle.
REQ-032 SHALL treat a pop in a flush cycle as consumed.
REQ-033 SHALL give rst priority over flush, and flush priority over accept/pop.
REQ-034 SHALL increment stall_cnt each cycle with out_valid && !out_ready, saturating at all ones.
REQ-035 SHALL increment bubble_cnt each cycle with out_valid=0 (excluding rst cycles), saturating at all ones.
REQ-036 SHALL leave the counters unaffected by flush.
REQ-037 SHALL update occ in the same edge as the state and keep it consistent with it (EMPTY=0, FULL=1, SKID=2).

Reset
REQ-038 SHALL, with rst high at an edge, set state EMPTY, occ=0, out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0 and bubble_cnt=0.
REQ-039 SHALL drive in_ready=1 during and after reset when SKID_EN=1.
REQ-040 SHALL drop any in-flight beat when rst is asserted mid-operation; no partial beat appears afterwards.

Verification
REQ-041 SHALL verify reset: after rst for 2 cycles -> out_valid=0, out_ctrl=0, occ=0, in_ready=1, stall_cnt=0, bubble_cnt=0.
REQ-042 SHALL verify streaming: in_valid=1 and out_ready=1 with in_data 1,2,3 on consecutive cycles -> out_data 1,2,3 one cycle later, occ=1 throughout and stall_cnt=0.
REQ-043 SHALL verify backpressure: accept A then B with out_ready=0 -> occ=2 and in_ready=0, with stall_cnt incrementing each cycle; raising out_ready then yields A, then B, then out_valid=0.
REQ-044 SHALL verify flush in SKID with in_valid=1 carrying C -> next cycle occ=0, out_valid=0 and out_ctrl=0; A, B and C never appear.
REQ-045 SHALL verify saturation with CNT_W=4: out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=15 and remains 15.
REQ-046 SHALL verify SKID_EN=0: full stage with out_ready=0 -> in_ready=0 in the same cycle; out_ready=1 with in_valid=1 and D -> pop and accept in the same cycle, and D appears next cycle.
